// File: rtl/uart_sched_if.sv
// uart_sched_if: register bus between the scheduler and the 8251-style serial port wrapper
interface uart_sched_if;
    logic       u_addr;
    logic       u_rd;
    logic       u_we;
    logic [7:0] u_wdata;
    logic [7:0] u_rdata;
    modport master (output u_addr, u_rd, u_we, u_wdata, input u_rdata);
    modport slave  (input u_addr, u_rd, u_we, u_wdata, output u_rdata);
endinterface

// File: rtl/uart_sched.sv
// uart_sched: status poller, rx drain and round-robin tx arbiter for an 8251-style serial port
module uart_sched #(
    parameter int TX_GUARD = 2
) (
    input  logic         clk,
    input  logic         resetn,
    uart_sched_if.master bus,
    input  logic [7:0]   tx0_data,
    input  logic [7:0]   tx1_data,
    input  logic         tx0_valid,
    input  logic         tx1_valid,
    output logic         tx0_ready,
    output logic         tx1_ready,
    output logic [7:0]   rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         last_grant,
    output logic         busy
);
    localparam int GW = TX_GUARD > 1 ? $clog2(TX_GUARD) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(TX_GUARD > 0 ? TX_GUARD - 1 : 0);

    typedef enum logic [2:0] {IDLE, POLL, SAMPLE, RD, CAPTURE, WR, GUARD} state_t;

    state_t        st_q;
    logic          u_addr_q, u_rd_q, u_we_q;
    logic [7:0]    u_wdata_q, rx_data_q;
    logic          tx0_ready_q, tx1_ready_q, rx_valid_q, last_grant_q, busy_q, win_q;
    logic [GW-1:0] cnt_q;
    logic          win_d;

    assign win_d = (tx0_valid && tx1_valid) ? !last_grant_q : tx1_valid;

    assign bus.u_addr  = u_addr_q;
    assign bus.u_rd    = u_rd_q;
    assign bus.u_we    = u_we_q;
    assign bus.u_wdata = u_wdata_q;
    assign tx0_ready   = tx0_ready_q;
    assign tx1_ready   = tx1_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign last_grant  = last_grant_q;
    assign busy        = busy_q;

    // sequencer: every bus strobe and handshake is set on entry to the state that owns it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q         <= IDLE;
            u_addr_q     <= 1'b0;
            u_rd_q       <= 1'b0;
            u_we_q       <= 1'b0;
            u_wdata_q    <= 8'h00;
            tx0_ready_q  <= 1'b0;
            tx1_ready_q  <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
            case (st_q)
                IDLE: begin
                    st_q     <= POLL;
                    u_rd_q   <= 1'b1;
                    u_addr_q <= 1'b1;
                    busy_q   <= 1'b1;
                end
                POLL: begin
                    st_q     <= SAMPLE;
                    u_rd_q   <= 1'b0;
                    u_addr_q <= 1'b0;
                end
                SAMPLE: begin
                    if (bus.u_rdata[1] && !rx_valid_q) begin
                        st_q   <= RD;
                        u_rd_q <= 1'b1;
                    end else if (bus.u_rdata[0] && (tx0_valid || tx1_valid)) begin
                        st_q        <= WR;
                        win_q       <= win_d;
                        u_we_q      <= 1'b1;
                        u_wdata_q   <= win_d ? tx1_data : tx0_data;
                        tx0_ready_q <= !win_d;
                        tx1_ready_q <= win_d;
                    end else begin
                        st_q   <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RD: begin
                    st_q   <= CAPTURE;
                    u_rd_q <= 1'b0;
                end
                CAPTURE: begin
                    st_q       <= IDLE;
                    rx_data_q  <= bus.u_rdata;
                    rx_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                WR: begin
                    u_we_q       <= 1'b0;
                    u_wdata_q    <= 8'h00;
                    tx0_ready_q  <= 1'b0;
                    tx1_ready_q  <= 1'b0;
                    last_grant_q <= win_q;
                    cnt_q        <= '0;
                    st_q         <= (TX_GUARD == 0) ? IDLE : GUARD;
                    busy_q       <= (TX_GUARD != 0);
                end
                GUARD: begin
                    cnt_q  <= cnt_q + 1'b1;
                    st_q   <= (cnt_q == G_LAST) ? IDLE : GUARD;
                    busy_q <= (cnt_q != G_LAST);
                end
                default: begin
                    st_q   <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sched.sv
// tb_uart_sched: scoreboard bench for the serial port scheduler with a register-level port model
module tb_uart_sched;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx0_data, tx1_data, rx_data, status, rxbyte;
    logic       tx0_valid, tx1_valid, tx0_ready, tx1_ready, rx_valid, rx_ready, last_grant, busy;
    int         vectors = 0, errors = 0, cyc = 0, last_poll = 0, overlap = 0;
    logic [8:0] wr_q[$];
    logic [7:0] rx_q[$];

    uart_sched_if bus();

    uart_sched #(.TX_GUARD(2)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .tx0_data(tx0_data), .tx1_data(tx1_data),
        .tx0_valid(tx0_valid), .tx1_valid(tx1_valid),
        .tx0_ready(tx0_ready), .tx1_ready(tx1_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .last_grant(last_grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // serial port model: a read returns the addressed register on the next cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.u_rd) bus.u_rdata <= bus.u_addr ? status : rxbyte;
    end

    // bus monitor: remembers the last status poll and counts rd/we collisions
    always @(negedge clk) begin
        if (bus.u_rd && bus.u_addr) last_poll = cyc;
        if (bus.u_rd && bus.u_we) overlap++;
    end

    task automatic do_reset;
        @(negedge clk);
        resetn = 1'b0;
        tx0_valid = 1'b0; tx1_valid = 1'b0; rx_ready = 1'b0;
        status = 8'h00; rxbyte = 8'h00; tx0_data = 8'h00; tx1_data = 8'h00;
        wr_q.delete(); rx_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        bit hit;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.u_addr, bus.u_rd, bus.u_we, tx0_ready, tx1_ready, rx_valid, busy} !== 7'b0) begin
            errors++; $display("FAIL rst_strobes: got %b required 0000000", {bus.u_addr, bus.u_rd, bus.u_we, tx0_ready, tx1_ready, rx_valid, busy});
        end
        vectors++;
        if ({bus.u_wdata, rx_data} !== 16'h0) begin
            errors++; $display("FAIL rst_data: got %h required 0000", {bus.u_wdata, rx_data});
        end
        vectors++;
        if (last_grant !== 1'b1) begin
            errors++; $display("FAIL rst_grant: got %b required 1", last_grant);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.u_rd, bus.u_addr, busy} !== 3'b111) begin
            errors++; $display("FAIL rst_first_poll: rd/addr/busy got %b required 111", {bus.u_rd, bus.u_addr, busy});
        end
        status = 8'h01; tx1_data = 8'h77; tx1_valid = 1'b1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = bus.u_we;
        end
        vectors++;
        if (!hit) begin
            errors++; $display("FAIL rst_wr_wait: u_we got 0 within 20 cycles required 1");
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({bus.u_we, tx1_ready, busy, bus.u_wdata} !== 11'h0) begin
            errors++; $display("FAIL rst_mid_wr: we/ready/busy/wdata got %h required 000", {bus.u_we, tx1_ready, busy, bus.u_wdata});
        end
        tx1_valid = 1'b0; status = 8'h00;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({last_grant, bus.u_rd, bus.u_addr} !== 3'b111) begin
            errors++; $display("FAIL rst_after_wr: grant/rd/addr got %b required 111", {last_grant, bus.u_rd, bus.u_addr});
        end
    endtask

    task automatic test_single_tx;
        bit hit;
        logic [8:0] exp;
        int wr_c;
        do_reset();
        status = 8'h01; tx0_data = 8'h41; tx0_valid = 1'b1;
        wr_q.push_back({1'b0, 8'h41});
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = bus.u_we;
        end
        vectors++;
        if (!hit) begin
            errors++; $display("FAIL tx_wait: u_we got 0 within 20 cycles required 1");
        end else begin
            exp = wr_q.pop_front();
            wr_c = cyc;
            tx0_valid = 1'b0;
            vectors++;
            if (bus.u_wdata !== exp[7:0]) begin
                errors++; $display("FAIL tx_data: got %h required %h", bus.u_wdata, exp[7:0]);
            end
            vectors++;
            if ({tx0_ready, tx1_ready, bus.u_addr, bus.u_rd} !== 4'b1000) begin
                errors++; $display("FAIL tx_strobes: ready0/ready1/addr/rd got %b required 1000", {tx0_ready, tx1_ready, bus.u_addr, bus.u_rd});
            end
            vectors++;
            if (cyc - last_poll !== 2) begin
                errors++; $display("FAIL tx_latency: got %0d required 2", cyc - last_poll);
            end
            @(negedge clk);
            vectors++;
            if ({tx0_ready, last_grant} !== 2'b00) begin
                errors++; $display("FAIL tx_pulse: ready0/grant got %b required 00", {tx0_ready, last_grant});
            end
            hit = 0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                hit = bus.u_rd && bus.u_addr;
            end
            vectors++;
            if (cyc - wr_c !== 4) begin
                errors++; $display("FAIL tx_guard: next poll got %0d cycles after WR required 4", cyc - wr_c);
            end
        end
    endtask

    task automatic test_round_robin;
        bit hit;
        logic [8:0] exp;
        do_reset();
        status = 8'h01; tx0_data = 8'h10; tx1_data = 8'h20;
        tx0_valid = 1'b1; tx1_valid = 1'b1;
        wr_q.push_back({1'b0, 8'h10});
        wr_q.push_back({1'b1, 8'h20});
        wr_q.push_back({1'b0, 8'h11});
        wr_q.push_back({1'b1, 8'h21});
        for (int k = 0; k < 4; k++) begin
            hit = 0;
            for (int i = 0; i < 30 && !hit; i++) begin
                @(negedge clk);
                hit = bus.u_we;
            end
            vectors++;
            if (!hit) begin
                errors++; $display("FAIL rr_wait%0d: u_we got 0 within 30 cycles required 1", k);
                break;
            end
            exp = wr_q.pop_front();
            vectors++;
            if (bus.u_wdata !== exp[7:0]) begin
                errors++; $display("FAIL rr_data%0d: got %h required %h", k, bus.u_wdata, exp[7:0]);
            end
            vectors++;
            if ({tx0_ready, tx1_ready} !== (exp[8] ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_ready%0d: got %b required %b", k, {tx0_ready, tx1_ready}, exp[8] ? 2'b01 : 2'b10);
            end
            if (tx0_ready) tx0_data = tx0_data + 8'd1;
            if (tx1_ready) tx1_data = tx1_data + 8'd1;
        end
        tx0_valid = 1'b0; tx1_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (last_grant !== 1'b1) begin
            errors++; $display("FAIL rr_grant: got %b required 1", last_grant);
        end
    endtask

    task automatic test_rx;
        bit hit;
        logic [7:0] exp;
        do_reset();
        status = 8'h02; rxbyte = 8'h5A; rx_ready = 1'b1;
        rx_q.push_back(8'h5A);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = bus.u_rd && !bus.u_addr;
        end
        vectors++;
        if (!hit) begin
            errors++; $display("FAIL rx_wait: data read got none within 20 cycles required one");
        end else begin
            vectors++;
            if ({bus.u_we, rx_valid} !== 2'b00 || cyc - last_poll !== 2) begin
                errors++; $display("FAIL rx_rd: we/valid got %b at +%0d required 00 at +2", {bus.u_we, rx_valid}, cyc - last_poll);
            end
            @(negedge clk);
            rx_ready = 1'b0; status = 8'h00;
            vectors++;
            if (rx_valid !== 1'b0) begin
                errors++; $display("FAIL rx_capture_early: got %b required 0", rx_valid);
            end
            @(negedge clk);
            exp = rx_q.pop_front();
            vectors++;
            if ({rx_valid, rx_data} !== {1'b1, exp} || cyc - last_poll !== 4) begin
                errors++; $display("FAIL rx_capture: valid/data got %b/%h at +%0d required 1/%h at +4", rx_valid, rx_data, cyc - last_poll, exp);
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            vectors++;
            if (rx_valid !== 1'b0) begin
                errors++; $display("FAIL rx_consume: got %b required 0", rx_valid);
            end
        end
    endtask

    task automatic test_rx_backpressure;
        bit hit;
        logic [8:0] exp;
        int nrd;
        do_reset();
        status = 8'h02; rxbyte = 8'h33;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            hit = rx_valid;
        end
        vectors++;
        if (!hit || rx_data !== 8'h33) begin
            errors++; $display("FAIL bp_fill: valid/data got %b/%h required 1/33", rx_valid, rx_data);
        end
        status = 8'h03; rxbyte = 8'h99; tx1_data = 8'h66; tx1_valid = 1'b1;
        wr_q.push_back({1'b1, 8'h66});
        nrd = 0; hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (bus.u_rd && !bus.u_addr) nrd++;
            hit = bus.u_we;
        end
        vectors++;
        if (!hit) begin
            errors++; $display("FAIL bp_wait: u_we got 0 within 30 cycles required 1");
        end else begin
            exp = wr_q.pop_front();
            tx1_valid = 1'b0;
            vectors++;
            if ({tx0_ready, tx1_ready, bus.u_wdata} !== {exp[8] ? 2'b01 : 2'b10, exp[7:0]}) begin
                errors++; $display("FAIL bp_write: ready/data got %b/%h required 01/%h", {tx0_ready, tx1_ready}, bus.u_wdata, exp[7:0]);
            end
        end
        repeat (15) begin
            @(negedge clk);
            if (bus.u_rd && !bus.u_addr) nrd++;
        end
        vectors++;
        if (nrd !== 0) begin
            errors++; $display("FAIL bp_no_read: data reads got %0d required 0", nrd);
        end
        vectors++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h33}) begin
            errors++; $display("FAIL bp_hold: valid/data got %b/%h required 1/33", rx_valid, rx_data);
        end
    endtask

    task automatic test_priority;
        bit hit;
        logic [8:0] exp;
        logic [7:0] erx;
        int rd_c;
        do_reset();
        status = 8'h03; rxbyte = 8'hC3; tx0_data = 8'h55; tx0_valid = 1'b1;
        wr_q.push_back({1'b0, 8'h55});
        rx_q.push_back(8'hC3);
        rd_c = -1; hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.u_rd && !bus.u_addr && rd_c < 0) rd_c = cyc;
            hit = bus.u_we;
        end
        vectors++;
        if (!hit) begin
            errors++; $display("FAIL prio_wait: u_we got 0 within 40 cycles required 1");
        end else begin
            exp = wr_q.pop_front();
            erx = rx_q.pop_front();
            tx0_valid = 1'b0;
            vectors++;
            if (cyc - rd_c !== 5) begin
                errors++; $display("FAIL prio_order: write got %0d cycles after data read required 5", cyc - rd_c);
            end
            vectors++;
            if ({tx0_ready, bus.u_wdata} !== {1'b1, exp[7:0]}) begin
                errors++; $display("FAIL prio_write: ready0/data got %b/%h required 1/%h", tx0_ready, bus.u_wdata, exp[7:0]);
            end
            vectors++;
            if ({rx_valid, rx_data} !== {1'b1, erx}) begin
                errors++; $display("FAIL prio_rx: valid/data got %b/%h required 1/%h", rx_valid, rx_data, erx);
            end
        end
        vectors++;
        if (overlap !== 0) begin
            errors++; $display("FAIL rd_we_overlap: got %0d cycles required 0", overlap);
        end
    endtask

    initial begin
        tx0_valid = 1'b0; tx1_valid = 1'b0; rx_ready = 1'b0;
        status = 8'h00; rxbyte = 8'h00; tx0_data = 8'h00; tx1_data = 8'h00;
        test_reset();
        test_single_tx();
        test_round_robin();
        test_rx();
        test_rx_backpressure();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
